// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding
// and default schedule parameters.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int STEPS_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter for the RUN phase of the multiply/divide sequencer.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   clr         force count to 0 (priority over en)
//   en          advance count by one
//   count       current iteration index
//   last        count == STEPS-1
module iter_counter
    import multdiv_pkg::*;
#(
    parameter int STEPS = STEPS_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(STEPS - 1);

    // Saturates at LAST_VAL so the index never wraps even if en lingers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !last) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/multdiv_sequencer.sv
// Control sequencer for the iterative multiply/divide datapath.
// Takes start pulses from decode, drives operand load and per-iteration step
// enables for a fixed STEPS-cycle schedule, and reports result-ready plus
// exception (divide-by-zero or multiply overflow). All outputs are flops.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   ctrl_mult      start multiply (wins over ctrl_div)
//   ctrl_div       start divide
//   divisor_zero   operand B == 0, sampled with the start pulse
//   ovf_in         multiply overflow, sampled at the end of the last RUN cycle
//   load_operands  datapath loads operands this cycle
//   step_en        datapath performs one iteration this cycle
//   first_step     with step_en on iteration 0
//   step_count     current iteration index
//   op_is_div      current/last operation is a divide
//   busy           LOAD or RUN
//   result_rdy     one-cycle result-valid pulse
//   exception      qualifies result_rdy
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = STEPS_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    input  logic             ovf_in,
    output logic             load_operands,
    output logic             step_en,
    output logic             first_step,
    output logic [CNT_W-1:0] step_count,
    output logic             op_is_div,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    if (WIDTH < 1 || STEPS < 1 || STEPS > 63 || (STEPS - 1) >= (1 << CNT_W)) begin : g_bad_cfg
        $error("multdiv_sequencer: illegal WIDTH/STEPS/CNT_W combination");
    end

    state_t state, state_nx;
    logic   div0, div0_nx;
    logic   ovf, ovf_nx;
    logic   op_div_nx;
    logic   cnt_clr, cnt_en, cnt_last;
    logic   start;

    iter_counter #(
        .STEPS (STEPS),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (step_count),
        .last  (cnt_last)
    );

    assign start = ctrl_mult | ctrl_div;

    always_comb begin
        state_nx  = state;
        div0_nx   = div0;
        ovf_nx    = ovf;
        op_div_nx = op_is_div;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        if (start) begin
            // A start in any state restarts; an in-flight result is dropped.
            state_nx  = LOAD;
            op_div_nx = ctrl_div & ~ctrl_mult;
            div0_nx   = ctrl_div & ~ctrl_mult & divisor_zero;
            ovf_nx    = 1'b0;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: state_nx = IDLE;
                LOAD: begin
                    cnt_clr  = 1'b1;
                    state_nx = div0 ? FINISH : RUN;
                end
                RUN: begin
                    if (cnt_last) begin
                        ovf_nx   = ovf_in & ~op_is_div;
                        state_nx = FINISH;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                FINISH:  state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            div0          <= 1'b0;
            ovf           <= 1'b0;
            op_is_div     <= 1'b0;
            load_operands <= 1'b0;
            step_en       <= 1'b0;
            first_step    <= 1'b0;
            busy          <= 1'b0;
            result_rdy    <= 1'b0;
            exception     <= 1'b0;
        end else begin
            state         <= state_nx;
            div0          <= div0_nx;
            ovf           <= ovf_nx;
            op_is_div     <= op_div_nx;
            load_operands <= (state_nx == LOAD);
            step_en       <= (state_nx == RUN);
            first_step    <= (state == LOAD) && (state_nx == RUN);
            busy          <= (state_nx == LOAD) || (state_nx == RUN);
            result_rdy    <= (state_nx == FINISH);
            exception     <= (state_nx == FINISH) && (div0_nx || ovf_nx);
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ctrl_mult, ctrl_div, divisor_zero, ovf_in;
    logic       load_operands, step_en, first_step, op_is_div, busy, result_rdy, exception;
    logic [5:0] step_count;

    int checks = 0;
    int passed = 0;

    multdiv_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .divisor_zero  (divisor_zero),
        .ovf_in        (ovf_in),
        .load_operands (load_operands),
        .step_en       (step_en),
        .first_step    (first_step),
        .step_count    (step_count),
        .op_is_div     (op_is_div),
        .busy          (busy),
        .result_rdy    (result_rdy),
        .exception     (exception)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {load_operands, step_en, first_step, busy, result_rdy, exception, step_count}
    function automatic logic [11:0] obs();
        return {load_operands, step_en, first_step, busy, result_rdy, exception, step_count};
    endfunction

    // Expected vector n cycles after the start edge for a 32-step operation.
    function automatic logic [11:0] exp_norm(int n, logic exc);
        logic [11:0] v;
        v = '0;
        if (n == 1)
            v = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0};
        else if (n >= 2 && n <= 33)
            v = {1'b0, 1'b1, (n == 2), 1'b1, 1'b0, 1'b0, 6'(n - 2)};
        else if (n == 34)
            v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exc, 6'd31};
        else
            v = {6'b0, 6'd31};
        return v;
    endfunction

    // Stimulus only: present a one-cycle start, return at cycle 1 after it.
    task automatic pulse(input logic m, input logic d, input logic dz);
        ctrl_mult    = m;
        ctrl_div     = d;
        divisor_zero = dz;
        @(negedge clk);
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        divisor_zero = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        reset = 1'b1; ctrl_mult = 0; ctrl_div = 0; divisor_zero = 0; ovf_in = 0;
        repeat (2) @(negedge clk);
        got = {obs(), op_is_div};
        checks++;
        if (got !== 13'd0) $display("FAIL reset_state got %b want %b", got, 13'd0);
        else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        got = {obs(), op_is_div};
        checks++;
        if (got !== 13'd0) $display("FAIL idle_after_reset got %b want %b", got, 13'd0);
        else passed++;
    endtask

    task automatic test_multiply(input int ovf_at, input logic exc, input string name);
        pulse(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 36; n++) begin
            checks++;
            if (obs() !== exp_norm(n, exc) || op_is_div !== 1'b0)
                $display("FAIL %s cycle %0d got %b/%b want %b/0", name, n, obs(), op_is_div, exp_norm(n, exc));
            else passed++;
            ovf_in = (ovf_at >= 0) && (n == ovf_at + 2);
            @(negedge clk);
        end
        ovf_in = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [12:0] got;
        pulse(1'b1, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        checks++;
        if (step_count !== 6'd10) $display("FAIL pre_reset_count got %0d want 10", step_count);
        else passed++;
        #2 reset = 1'b1;
        #1 got = {obs(), op_is_div};
        checks++;
        if (got !== 13'd0) $display("FAIL async_reset got %b want %b", got, 13'd0);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            checks++;
            if (result_rdy !== 1'b0 || busy !== 1'b0)
                $display("FAIL no_rdy_after_reset cycle %0d got rdy=%b busy=%b want 0/0", n, result_rdy, busy);
            else passed++;
        end
        test_multiply(-1, 1'b0, "mult_after_reset");
    endtask

    task automatic test_div_zero();
        logic [12:0] want;
        pulse(1'b0, 1'b1, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            if (n == 1)      want = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1};
            else if (n == 2) want = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b1};
            else             want = {6'b0, 6'd0, 1'b1};
            checks++;
            if ({obs(), op_is_div} !== want)
                $display("FAIL div_zero cycle %0d got %b want %b", n, {obs(), op_is_div}, want);
            else passed++;
            ovf_in = 1'b1;
            @(negedge clk);
        end
        ovf_in = 1'b0;
    endtask

    task automatic test_abort();
        pulse(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 22; n++) begin
            checks++;
            if (obs() !== exp_norm(n, 1'b0))
                $display("FAIL abort_first cycle %0d got %b want %b", n, obs(), exp_norm(n, 1'b0));
            else passed++;
            if (n < 22) @(negedge clk);
        end
        // Divide restart at step_count 20; overflow held high must be ignored.
        ovf_in = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 36; n++) begin
            checks++;
            if (obs() !== exp_norm(n, 1'b0) || op_is_div !== 1'b1)
                $display("FAIL abort_div cycle %0d got %b/%b want %b/1", n, obs(), op_is_div, exp_norm(n, 1'b0));
            else passed++;
            @(negedge clk);
        end
        ovf_in = 1'b0;
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 1'b1, 1'b1);
        for (int n = 1; n <= 35; n++) begin
            checks++;
            if (obs() !== exp_norm(n, 1'b0) || op_is_div !== 1'b0)
                $display("FAIL simultaneous cycle %0d got %b/%b want %b/0", n, obs(), op_is_div, exp_norm(n, 1'b0));
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] want;
        pulse(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 33; n++) begin
            checks++;
            if (obs() !== exp_norm(n, 1'b0))
                $display("FAIL b2b_first cycle %0d got %b want %b", n, obs(), exp_norm(n, 1'b0));
            else passed++;
            if (n < 33) @(negedge clk);
        end
        // Start on the edge ending the last RUN cycle: old result never flagged.
        pulse(1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 34; n++) begin
            checks++;
            if (obs() !== exp_norm(n, 1'b0))
                $display("FAIL b2b_restart cycle %0d got %b want %b", n, obs(), exp_norm(n, 1'b0));
            else passed++;
            if (n < 34) @(negedge clk);
        end
        // Start during FINISH goes straight to LOAD.
        pulse(1'b0, 1'b1, 1'b1);
        for (int n = 1; n <= 3; n++) begin
            if (n == 1)      want = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1};
            else if (n == 2) want = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b1};
            else             want = {6'b0, 6'd0, 1'b1};
            checks++;
            if ({obs(), op_is_div} !== want)
                $display("FAIL b2b_finish_start cycle %0d got %b want %b", n, {obs(), op_is_div}, want);
            else passed++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_multiply(-1, 1'b0, "mult_plain");
        test_multiply(31, 1'b1, "mult_ovf_last");
        test_multiply(5, 1'b0, "mult_ovf_early");
        test_reset_mid_run();
        test_div_zero();
        test_abort();
        test_simultaneous();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control sequencer for the iterative multiply/divide datapath in the processor.
- Accepts one-cycle start pulses from decode and drives operand load and per-iteration step enables.
- Runs a fixed STEPS-iteration schedule and reports result-ready and exception back to the pipeline.
- Owns the iteration counter, so the datapath contains no counting logic.

Parameters:
- WIDTH, 32, operand width of the datapath.
- STEPS, 32, number of iteration cycles per operation; must be ≥ 1 and ≤ 63.
- CNT_W, 6, width of step_count; must hold STEPS-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ctrl_mult  input  1  start-multiply pulse, sampled on clk rise.
- ctrl_div  input  1  start-divide pulse, sampled on clk rise.
- divisor_zero  input  1  datapath flag: operand B == 0; sampled on the same edge as the start pulse.
- ovf_in  input  1  datapath multiply-overflow flag; sampled on the edge ending the last RUN cycle.
- load_operands  output  1  datapath loads operand/partial registers this cycle.
- step_en  output  1  datapath performs one iteration this cycle.
- first_step  output  1  high with step_en when step_count == 0.
- step_count  output  CNT_W  current iteration index.
- op_is_div  output  1  1 = division in progress or finished; 0 = multiply.
- busy  output  1  high in LOAD and RUN.
- result_rdy  output  1  one-cycle pulse; result valid.
- exception  output  1  valid while result_rdy = 1; 0 otherwise.

Behaviour:
- All outputs are registered (Moore).
- States: IDLE, LOAD, RUN, FINISH.
- Reset, asserted at any time:
  - state = IDLE.
  - All outputs = 0, step_count = 0.
  - Internal div0 flag and ovf flag cleared.
  - Any in-flight operation is discarded, with no result_rdy.
- Start detection, any state, on clk rise:
  - If ctrl_mult or ctrl_div is high: next state = LOAD, op_is_div <= ctrl_div & ~ctrl_mult, div0 <= ctrl_div & ~ctrl_mult & divisor_zero.
  - If both are high, multiply wins.
- Aborts:
  - A start while in LOAD or RUN aborts the current operation; no result_rdy is issued for it.
  - A start sampled on the edge ending the last RUN cycle also aborts; the old result is never flagged.
- LOAD (1 cycle): load_operands = 1, busy = 1.
  - If div0: next state = FINISH, skipping RUN.
  - Else: next state = RUN, step_count = 0.
- RUN (STEPS cycles):
  - step_en = 1, busy = 1.
  - first_step = 1 only in the first cycle.
  - step_count counts 0..STEPS-1 and increments each edge.
  - On the edge ending the cycle with step_count = STEPS-1: ovf flag <= ovf_in & ~op_is_div, next state = FINISH.
  - No wrap-around; step_count never exceeds STEPS-1.
- FINISH (1 cycle): result_rdy = 1, busy = 0, exception = div0 | ovf flag.
  - Next state = IDLE, or LOAD if a start is sampled.
- IDLE: all strobes 0. op_is_div holds its last value.
- Latency, counting edges after the edge that samples the start pulse:
  - Normal operation: result_rdy is high during the cycle after edge STEPS+1, i.e. STEPS+2 cycles after start. For STEPS = 32 this is 34 cycles.
  - Divide-by-zero: result_rdy follows 2 cycles after start, with exception = 1.
- ovf_in and divisor_zero are ignored outside their sampling edges.

Decomposition:
- Shared package (multdiv_pkg):
  - State encoding constants: IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, FINISH = 2'd3.
  - Defaults for STEPS and CNT_W.
- Sub-module iter_counter holds the RUN-state iteration count:
  - Inputs: clk, reset, clr, en.
  - Outputs: count [CNT_W-1:0], last (count == STEPS-1).
  - clr has priority over en.
- The FSM and flag registers live in multdiv_sequencer.

Test Plan:
- Reset mid-RUN: assert reset at step_count = 10 → all outputs 0 immediately; no result_rdy follows; next ctrl_mult runs a full 34-cycle operation.
- Multiply: one-cycle ctrl_mult, ovf_in = 0 → load_operands 1 cycle later; 32 step_en cycles with step_count 0..31; first_step only at 0; result_rdy single pulse 34 cycles after start; exception = 0.
- Multiply overflow: ovf_in = 1 at step_count = 31 only → result_rdy at cycle 34 with exception = 1; ovf_in = 1 only at step_count = 5 → exception = 0.
- Divide by zero: ctrl_div with divisor_zero = 1 → LOAD, then FINISH; result_rdy at cycle 2 with exception = 1 and op_is_div = 1; step_en never asserted.
- Abort and simultaneous start: ctrl_div at step_count = 20 of a multiply → new LOAD, step_count restarts at 0, op_is_div = 1, exactly one result_rdy 34 cycles after the second start. ctrl_mult and ctrl_div together → op_is_div = 0.
